cu_chan_sched: RTL and testbench

Sequential round-robin scheduler for the shared 4-channel cu command decoder.
- Accepts per-channel requests.
- Masks channels reporting busy.
- Grants one channel at a time, presenting a 2-bit select plus a one-hot grant to the decoder.
- Holds the grant through the decoder's command handshake and the channel's completion.
- Sits between the requester front-ends and the decoder's select/enable inputs.

---
 rtl/cu_sched_pkg.sv | 21 ++
 rtl/cu_rr_pick.sv | 28 ++
 rtl/cu_chan_sched.sv | 155 +++++++++++++++
 tb/tb_cu_chan_sched.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/cu_sched_pkg.sv
// Shared types and constants for the cu channel scheduler.
package cu_sched_pkg;

    localparam int NCH     = 4;
    localparam int SELW    = 2;
    localparam int TIMEOUT = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } sched_state_e;

    function automatic logic [NCH-1:0] sel_to_onehot(input logic [SELW-1:0] sel);
        logic [NCH-1:0] oh;
        oh      = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/cu_rr_pick.sv
// Round-robin picker: first eligible channel after ptr, wrapping, with ptr itself last.
module cu_rr_pick
    import cu_sched_pkg::*;
(
    input  logic [NCH-1:0]  elig,
    input  logic [SELW-1:0] ptr,
    output logic            any,
    output logic [SELW-1:0] pick
);

    logic [SELW-1:0] idx;
    logic            found;

    always_comb begin
        any   = |elig;
        pick  = ptr;
        found = 1'b0;
        idx   = ptr;
        for (int i = 1; i <= NCH; i++) begin
            idx = ptr + SELW'(i);
            if (!found && elig[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cu_chan_sched.sv
// Round-robin grant scheduler for the shared 4-channel cu command decoder.
// Optional grant timeout enabled by defining CU_SCHED_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no grant; searching eligible requests
// ISSUE | grant held, command strobe to decoder until cmd_ok
// WAIT  | command accepted, grant held until channel reports done
module cu_chan_sched
    import cu_sched_pkg::*;
`ifdef CU_SCHED_TIMEOUT_EN
#(
    parameter int TIMEOUT = cu_sched_pkg::TIMEOUT
)
`endif
(
    input  logic            clk,
    input  logic            rst,
    input  logic [NCH-1:0]  req,
    input  logic [NCH-1:0]  busy,
    input  logic            cmd_ok,
    input  logic            done,
    output logic            grant_vld,
    output logic [SELW-1:0] grant_sel,
    output logic [NCH-1:0]  grant_oh,
    output logic            issue,
    output logic            active,
    output logic            err
);

    sched_state_e    state_q, state_d;
    logic [SELW-1:0] sel_q, sel_d;
    logic [NCH-1:0]  oh_q, oh_d;
    logic [SELW-1:0] ptr_q, ptr_d;
    logic            vld_q, vld_d;
    logic            issue_q, issue_d;
    logic            active_q, active_d;
    logic            err_q, err_d;

    logic            any;
    logic [SELW-1:0] pick;

    cu_rr_pick u_pick (
        .elig (req & ~busy),
        .ptr  (ptr_q),
        .any  (any),
        .pick (pick)
    );

`ifdef CU_SCHED_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       to_hit;
    assign to_hit = (cnt_q == 8'(TIMEOUT - 1));
`endif

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        oh_d    = oh_q;
        ptr_d   = ptr_q;
        err_d   = 1'b0;
`ifdef CU_SCHED_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (any) begin
                    state_d = ISSUE;
                    sel_d   = pick;
                    oh_d    = sel_to_onehot(pick);
`ifdef CU_SCHED_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ISSUE: begin
`ifdef CU_SCHED_TIMEOUT_EN
                cnt_d = cnt_q + 8'd1;
`endif
                // cmd_ok beats both an abandoning req drop and a timeout
                if (cmd_ok) begin
                    state_d = WAIT;
                end else if (!req[sel_q]) begin
                    state_d = IDLE;
`ifdef CU_SCHED_TIMEOUT_EN
                end else if (to_hit) begin
                    state_d = IDLE;
                    ptr_d   = sel_q;
                    err_d   = 1'b1;
`endif
                end
            end
            WAIT: begin
`ifdef CU_SCHED_TIMEOUT_EN
                cnt_d = cnt_q + 8'd1;
`endif
                if (done) begin
                    state_d = IDLE;
                    ptr_d   = sel_q;
`ifdef CU_SCHED_TIMEOUT_EN
                end else if (to_hit) begin
                    state_d = IDLE;
                    ptr_d   = sel_q;
                    err_d   = 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d == IDLE) begin
            sel_d = '0;
            oh_d  = '0;
        end
        vld_d    = (state_d != IDLE);
        issue_d  = (state_d == ISSUE);
        active_d = (state_d == WAIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            oh_q     <= '0;
            ptr_q    <= SELW'(NCH - 1);
            vld_q    <= 1'b0;
            issue_q  <= 1'b0;
            active_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            oh_q     <= oh_d;
            ptr_q    <= ptr_d;
            vld_q    <= vld_d;
            issue_q  <= issue_d;
            active_q <= active_d;
            err_q    <= err_d;
        end
    end

`ifdef CU_SCHED_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`endif

    assign grant_vld = vld_q;
    assign grant_sel = sel_q;
    assign grant_oh  = oh_q;
    assign issue     = issue_q;
    assign active    = active_q;
    assign err       = err_q;

endmodule

// File: tb/tb_cu_chan_sched.sv
// Scoreboard bench for cu_chan_sched: directed scenarios then random traffic against a reference model.
module tb_cu_chan_sched;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] busy = '0;
    logic       cmd_ok = 1'b0;
    logic       done = 1'b0;
    logic       grant_vld;
    logic [1:0] grant_sel;
    logic [3:0] grant_oh;
    logic       issue;
    logic       active;
    logic       err;

    always #5 clk = ~clk;

`ifdef CU_SCHED_TIMEOUT_EN
    cu_chan_sched #(.TIMEOUT(TO)) dut (
`else
    cu_chan_sched dut (
`endif
        .clk(clk), .rst(rst), .req(req), .busy(busy), .cmd_ok(cmd_ok), .done(done),
        .grant_vld(grant_vld), .grant_sel(grant_sel), .grant_oh(grant_oh),
        .issue(issue), .active(active), .err(err)
    );

    typedef struct packed {
        logic       vld;
        logic [1:0] sel;
        logic [3:0] oh;
        logic       iss;
        logic       act;
        logic       er;
    } out_t;

    out_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference model: phase 0 = no grant, 1 = command pending, 2 = awaiting completion
    int m_phase = 0;
    int m_owner = 0;
    int m_ptr   = 3;
    int m_held  = 0;
    bit m_err   = 0;

    task automatic model_step(input logic r, input logic [3:0] rq, input logic [3:0] bs,
                              input logic ck, input logic dn);
        logic [3:0] elig;
        bit found;
        int c;
        m_err = 0;
        if (r) begin
            m_phase = 0; m_owner = 0; m_ptr = 3; m_held = 0;
        end else if (m_phase == 0) begin
            elig = rq & ~bs;
            if (elig != 0) begin
                found = 0;
                for (int k = 1; k <= 4; k++) begin
                    c = (m_ptr + k) % 4;
                    if (!found && elig[c]) begin m_owner = c; found = 1; end
                end
                m_phase = 1;
                m_held  = 0;
            end
        end else begin
            m_held++;
            if (m_phase == 1 && ck) m_phase = 2;
            else if (m_phase == 1 && !rq[m_owner]) m_phase = 0;
            else if (m_phase == 2 && dn) begin m_phase = 0; m_ptr = m_owner; end
`ifdef CU_SCHED_TIMEOUT_EN
            else if (m_held >= TO) begin m_phase = 0; m_ptr = m_owner; m_err = 1; end
`endif
        end
    endtask

    task automatic cyc(input logic r, input logic [3:0] rq, input logic [3:0] bs,
                       input logic ck, input logic dn);
        out_t e;
        @(negedge clk);
        rst = r; req = rq; busy = bs; cmd_ok = ck; done = dn;
        model_step(r, rq, bs, ck, dn);
        e.vld = (m_phase != 0);
        e.sel = e.vld ? 2'(m_owner) : 2'd0;
        e.oh  = e.vld ? 4'(1 << m_owner) : 4'd0;
        e.iss = (m_phase == 1);
        e.act = (m_phase == 2);
        e.er  = m_err;
        exp_q.push_back(e);
    endtask

    always @(posedge clk) begin
        out_t a, e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{grant_vld, grant_sel, grant_oh, issue, active, err};
            n_chk++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL outputs t=%0t: got vld=%b sel=%0d oh=%b issue=%b active=%b err=%b, want vld=%b sel=%0d oh=%b issue=%b active=%b err=%b",
                         $time, a.vld, a.sel, a.oh, a.iss, a.act, a.er,
                         e.vld, e.sel, e.oh, e.iss, e.act, e.er);
            end
        end
    end

    initial begin
        // reset
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);

        // single request on channel 0
        cyc(0, 4'b0001, 0, 0, 0);
        cyc(0, 4'b0001, 0, 1, 0);
        cyc(0, 4'b0000, 0, 0, 1);
        cyc(0, 4'b0000, 0, 0, 0);

        // all requesting: rotation 0,1,2,3,0 with a bubble between grants
        cyc(1, 0, 0, 0, 0);
        for (int g = 0; g < 5; g++) begin
            cyc(0, 4'b1111, 0, 0, 0);
            cyc(0, 4'b1111, 0, 1, 0);
            cyc(0, 4'b1111, 0, 0, 0);
            cyc(0, 4'b1111, 0, 0, 1);
        end
        cyc(0, 0, 0, 0, 0);

        // busy masking then rotation to channel 1
        cyc(1, 0, 0, 0, 0);
        cyc(0, 4'b0110, 4'b0010, 0, 0);
        cyc(0, 4'b0110, 4'b0000, 1, 0);
        cyc(0, 4'b0110, 4'b0000, 0, 1);
        cyc(0, 4'b0010, 4'b0000, 0, 0);
        cyc(0, 4'b0010, 4'b0000, 1, 0);
        cyc(0, 4'b0000, 4'b0000, 0, 1);

        // abandon on channel 3, then drop coinciding with cmd_ok
        cyc(1, 0, 0, 0, 0);
        cyc(0, 4'b1000, 0, 0, 0);
        cyc(0, 4'b0000, 0, 0, 0);
        cyc(0, 4'b0000, 0, 0, 0);
        cyc(0, 4'b1000, 0, 0, 0);
        cyc(0, 4'b0000, 0, 1, 0);
        cyc(0, 4'b0000, 0, 0, 0);

        // reset while in WAIT, then channel 3 from fresh pointer
        cyc(1, 0, 0, 0, 0);
        cyc(0, 4'b1000, 0, 0, 0);
        cyc(0, 4'b1000, 0, 0, 0);
        cyc(0, 4'b1000, 0, 1, 0);
        cyc(0, 4'b0000, 0, 0, 0);
        cyc(0, 4'b1000, 0, 0, 0);

        // grant on channel 1 with cmd_ok withheld for a long stretch
        cyc(1, 0, 0, 0, 0);
        cyc(0, 4'b0001, 0, 0, 0);
        cyc(0, 4'b0001, 0, 1, 0);
        cyc(0, 4'b0000, 0, 0, 1);
        for (int i = 0; i < 300; i++) cyc(0, 4'b0010, 0, 0, 0);
        cyc(0, 4'b0000, 0, 0, 0);

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            cyc(($urandom_range(0, 199) == 0),
                4'($urandom),
                ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0,
                ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 3) == 0));
        end

        @(negedge clk);
        @(negedge clk);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
